booth_pipe_mult: RTL



---
 rtl/booth_pkg.sv | 38 +++
 rtl/booth_pp_gen.sv | 30 +++
 rtl/booth_pipe_mult.sv | 122 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared radix-4 Booth definitions: group encodings, group decode and
// width helpers used by the pipelined multiplier and its partial-product slices.
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_op_e;

  // Groups per operand: LENGTH/2 pairs plus one for the extension bits.
  function automatic int pp_num(input int length);
    return length / 2 + 1;
  endfunction

  function automatic int prod_width(input int length);
    return 2 * length;
  endfunction

  function automatic booth_op_e booth_decode(input logic [2:0] grp);
    booth_op_e op;
    case (grp)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

  function automatic logic op_is_neg(input booth_op_e op);
    return (op == NEG1) || (op == NEG2);
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth slice: selects 0, A or 2A from the extended multiplicand
// and inverts it for negative groups; the +1 completing the negation is neg.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH+1:0] a_ext,
  input  logic [2:0]        grp,
  output logic [LENGTH+1:0] pp,
  output logic              neg
);

  booth_op_e         op;
  logic [LENGTH+1:0] mag;

  always_comb begin
    op  = booth_decode(grp);
    mag = '0;
    case (op)
      POS1, NEG1: mag = a_ext;
      // 2A still fits: the extended multiplicand carries two guard bits.
      POS2, NEG2: mag = {a_ext[LENGTH:0], 1'b0};
      default:    mag = '0;
    endcase
    neg = op_is_neg(op);
    pp  = neg ? ~mag : mag;
  end

endmodule

// File: rtl/booth_pipe_mult.sv
// Three-stage radix-4 Booth multiplier (capture, partial products, sum) with
// per-transaction signed/unsigned mode and whole-pipeline stall on backpressure.
module booth_pipe_mult
  import booth_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  signed_i,
  input  logic [LENGTH-1:0]     a_i,
  input  logic [LENGTH-1:0]     b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*LENGTH-1:0]   p_o
);

  localparam int PP_NUM = pp_num(LENGTH);
  localparam int PW     = prod_width(LENGTH);
  localparam int XW     = LENGTH + 2;

  logic en;

  logic              s1_valid;
  logic [LENGTH-1:0] s1_a;
  logic [LENGTH-1:0] s1_b;
  logic              s1_signed;

  logic              s2_valid;
  logic [XW-1:0]     s2_pp [PP_NUM];
  logic [PP_NUM-1:0] s2_neg;

  logic              s3_valid;
  logic [PW-1:0]     s3_p;

  logic [XW-1:0]     a_ext;
  logic [LENGTH+2:0] b_ext;
  logic [XW-1:0]     pp_w [PP_NUM];
  logic [PP_NUM-1:0] neg_w;
  logic [PW-1:0]     ext_pp;
  logic [PW-1:0]     sum;

  // Stall only when a finished product is refused; bubbles keep moving otherwise.
  assign en          = !(s3_valid && !out_ready_i);
  assign in_ready_o  = en;
  assign out_valid_o = s3_valid;
  assign p_o         = s3_p;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid_i;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
    end else if (en && in_valid_i) begin
      s1_a      <= a_i;
      s1_b      <= b_i;
      s1_signed <= signed_i;
    end
  end

  // Two extension bits (sign or zero) plus the implicit 0 below the multiplier LSB.
  assign a_ext = {{2{s1_signed & s1_a[LENGTH-1]}}, s1_a};
  assign b_ext = {{2{s1_signed & s1_b[LENGTH-1]}}, s1_b, 1'b0};

  for (genvar k = 0; k < PP_NUM; k++) begin : g_pp
    booth_pp_gen #(
      .LENGTH (LENGTH)
    ) u_pp_gen (
      .a_ext (a_ext),
      .grp   (b_ext[2*k+2 -: 3]),
      .pp    (pp_w[k]),
      .neg   (neg_w[k])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < PP_NUM; k++) begin
        s2_pp[k] <= '0;
      end
      s2_neg <= '0;
    end else if (en && s1_valid) begin
      for (int k = 0; k < PP_NUM; k++) begin
        s2_pp[k] <= pp_w[k];
      end
      s2_neg <= neg_w;
    end
  end

  // Sign-extend each partial product, weight by 4^k, add its correction bit.
  always_comb begin
    sum    = '0;
    ext_pp = '0;
    for (int k = 0; k < PP_NUM; k++) begin
      ext_pp = {{(PW-XW){s2_pp[k][XW-1]}}, s2_pp[k]};
      sum    = sum + (ext_pp << (2*k)) + (PW'(s2_neg[k]) << (2*k));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s3_p <= '0;
    end else if (en && s2_valid) begin
      s3_p <= sum;
    end
  end

endmodule
